// File: rtl/vit_acs_sched.sv
`default_nettype none
// ============================================================================
// Module   : vit_acs_sched
// Purpose  : Symbol scheduler for a folded BMC/ACS bank in a hard-decision
//            Viterbi decoder. It steps the ACS bank through the state groups,
//            ping-pongs the metric banks and addresses survivor memory.
//            Define VIT_NORM_EN to enable path-metric normalization.
// Revision : 1.0 - initial release
// ============================================================================
module vit_acs_sched #(
  parameter int NUM_STATES = 64,
  parameter int ACS_UNITS  = 8,
  parameter int TB_DEPTH   = 32,
  localparam int G_NUM     = NUM_STATES / ACS_UNITS,
  localparam int GW        = (G_NUM > 1) ? $clog2(G_NUM) : 1,
  localparam int AW        = $clog2(TB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    rx_pair,
  input  logic          frame_start,
  input  logic          acs_msb_all,
  output logic [1:0]    rx_pair_q,
  output logic          acs_en,
  output logic [GW-1:0] grp_idx,
  output logic          pm_rd_bank,
  output logic          pm_init,
  output logic          norm_sub,
  output logic          sv_we,
  output logic [AW-1:0] sv_addr,
  output logic          sym_done,
  output logic          tb_req
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          live_q;
  logic [GW-1:0] grp_q, grp_d;
  logic [1:0]    pair_q, pair_d;
  logic          bank_q, bank_d;
  logic          init_q, init_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          accept;

`ifdef VIT_NORM_EN
  logic          pend_q, pend_d;
  logic          acc_q, acc_d;
`endif

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    pair_d   = pair_q;
    bank_d   = bank_q;
    init_d   = init_q;
    addr_d   = addr_q;
    in_ready = 1'b0;
    acs_en   = 1'b0;
    sym_done = 1'b0;
    tb_req   = 1'b0;
    accept   = 1'b0;
`ifdef VIT_NORM_EN
    pend_d   = pend_q;
    acc_d    = acc_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Held low until the first clock after reset release.
        in_ready = live_q;
      end
      S_RUN: begin
        acs_en = 1'b1;
`ifdef VIT_NORM_EN
        acc_d  = acc_q & acs_msb_all;
`endif
        if (grp_q == GW'(G_NUM - 1)) begin
          grp_d   = '0;
          state_d = S_COMMIT;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      S_COMMIT: begin
        sym_done = 1'b1;
        in_ready = 1'b1;
        // Survivor column and traceback count both clear on frame start and
        // wrap at TB_DEPTH, so the request fires as the column wraps.
        tb_req   = (addr_q == AW'(TB_DEPTH - 1));
        bank_d   = ~bank_q;
        init_d   = 1'b0;
        addr_d   = addr_q + 1'b1;
        state_d  = S_IDLE;
`ifdef VIT_NORM_EN
        pend_d   = acc_q;
        acc_d    = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    accept = in_valid & in_ready;
    if (accept) begin
      pair_d  = rx_pair;
      grp_d   = '0;
      state_d = S_RUN;
      if (frame_start) begin
        init_d = 1'b1;
        addr_d = '0;
`ifdef VIT_NORM_EN
        pend_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      grp_q   <= '0;
      pair_q  <= 2'b00;
      bank_q  <= 1'b0;
      init_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      grp_q   <= grp_d;
      pair_q  <= pair_d;
      bank_q  <= bank_d;
      init_q  <= init_d;
      addr_q  <= addr_d;
    end
  end

`ifdef VIT_NORM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      acc_q  <= 1'b1;
    end else begin
      pend_q <= pend_d;
      acc_q  <= acc_d;
    end
  end

  assign norm_sub = pend_q;
`else
  logic unused_msb;
  assign unused_msb = acs_msb_all;
  assign norm_sub   = 1'b0;
`endif

  assign rx_pair_q  = pair_q;
  assign grp_idx    = grp_q;
  assign pm_rd_bank = bank_q;
  assign pm_init    = init_q;
  assign sv_we      = acs_en;
  assign sv_addr    = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_vit_acs_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vit_acs_sched
// Purpose  : Self-checking bench for vit_acs_sched against a symbol-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vit_acs_sched;

  localparam int G   = 8;
  localparam int TBD = 32;

  logic       clk, rst, in_valid, in_ready, frame_start, acs_msb_all;
  logic       acs_en, pm_rd_bank, pm_init, norm_sub, sv_we, sym_done, tb_req;
  logic [1:0] rx_pair, rx_pair_q;
  logic [2:0] grp_idx;
  logic [4:0] sv_addr;

  int n_checks = 0;
  int n_err    = 0;
  // Symbol-level model: bank parity, column, symbols since request, pending norm.
  int m_bank, m_addr, m_cnt, m_pend;

  vit_acs_sched #(.NUM_STATES(64), .ACS_UNITS(8), .TB_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_pair(rx_pair), .frame_start(frame_start), .acs_msb_all(acs_msb_all),
    .rx_pair_q(rx_pair_q), .acs_en(acs_en), .grp_idx(grp_idx),
    .pm_rd_bank(pm_rd_bank), .pm_init(pm_init), .norm_sub(norm_sub),
    .sv_we(sv_we), .sv_addr(sv_addr), .sym_done(sym_done), .tb_req(tb_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst();
    check("rst_in_ready", in_ready, 0);
    check("rst_acs_en", acs_en, 0);
    check("rst_grp_idx", grp_idx, 0);
    check("rst_pm_rd_bank", pm_rd_bank, 0);
    check("rst_pm_init", pm_init, 0);
    check("rst_norm_sub", norm_sub, 0);
    check("rst_sv_we", sv_we, 0);
    check("rst_sv_addr", sv_addr, 0);
    check("rst_sym_done", sym_done, 0);
    check("rst_tb_req", tb_req, 0);
    check("rst_rx_pair_q", rx_pair_q, 0);
  endtask

  // Entered with the DUT ready (IDLE or COMMIT); leaves it in COMMIT when gap==0.
  task automatic do_sym(input logic [1:0] pair, input logic fs, input logic [7:0] msb,
                        input int gap);
    int exp_norm;
    check("accept_ready", in_ready, 1);
    if (fs) begin
      m_addr = 0;
      m_cnt  = 0;
      m_pend = 0;
    end
    exp_norm    = m_pend;
    in_valid    = 1'b1;
    rx_pair     = pair;
    frame_start = fs;
    tick();
    for (int g = 0; g < G; g++) begin
      // Inputs while busy must be ignored.
      in_valid    = 1'($urandom_range(0, 1));
      rx_pair     = 2'($urandom_range(0, 3));
      frame_start = 1'($urandom_range(0, 1));
      acs_msb_all = msb[g];
      check("run_acs_en", acs_en, 1);
      check("run_sv_we", sv_we, 1);
      check("run_grp_idx", grp_idx, g);
      check("run_rx_pair_q", rx_pair_q, pair);
      check("run_pm_init", pm_init, fs);
      check("run_pm_rd_bank", pm_rd_bank, m_bank);
      check("run_norm_sub", norm_sub, exp_norm);
      check("run_sv_addr", sv_addr, m_addr);
      check("run_in_ready", in_ready, 0);
      check("run_sym_done", sym_done, 0);
      check("run_tb_req", tb_req, 0);
      tick();
    end
    check("commit_sym_done", sym_done, 1);
    check("commit_acs_en", acs_en, 0);
    check("commit_in_ready", in_ready, 1);
    check("commit_tb_req", tb_req, (m_cnt + 1 == TBD));
    m_bank = m_bank ^ 1;
    m_cnt  = (m_cnt + 1) % TBD;
    m_addr = (m_addr + 1) % TBD;
`ifdef VIT_NORM_EN
    m_pend = &msb;
`else
    m_pend = 0;
`endif
    in_valid    = 1'b0;
    acs_msb_all = 1'($urandom_range(0, 1));
    for (int k = 0; k < gap; k++) begin
      frame_start = 1'($urandom_range(0, 1));
      rx_pair     = 2'($urandom_range(0, 3));
      tick();
      check("idle_acs_en", acs_en, 0);
      check("idle_sym_done", sym_done, 0);
      check("idle_tb_req", tb_req, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_pm_rd_bank", pm_rd_bank, m_bank);
      check("idle_pm_init", pm_init, 0);
      check("idle_sv_addr", sv_addr, m_addr);
      check("idle_norm_sub", norm_sub, m_pend);
    end
  endtask

  initial begin
    logic [7:0] msb;
    int         gap;
    rst = 1'b1; in_valid = 1'b0; rx_pair = 2'b00; frame_start = 1'b0; acs_msb_all = 1'b0;
    m_bank = 0; m_addr = 0; m_cnt = 0; m_pend = 0;
    tick();
    tick();
    check_rst();
    #3 rst = 1'b0;
    check("ready_before_clk", in_ready, 0);
    tick();
    check("ready_after_release", in_ready, 1);

    // Frame start, then two back-to-back symbols; second one arms normalization.
    do_sym(2'b10, 1'b1, 8'hFF, 0);
    do_sym(2'($urandom_range(0, 3)), 1'b0, 8'hFF, 0);
    do_sym(2'($urandom_range(0, 3)), 1'b0, 8'hF7, 2);

    // Random stream: traceback request at symbol 32, new frame at column 17.
    for (int i = 0; i < 60; i++) begin
      msb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (i == 59) gap = 1;
      do_sym(2'($urandom_range(0, 3)), (i == 0) || (i == 49), msb, gap);
    end

    // Reset in the middle of RUN.
    in_valid = 1'b1; rx_pair = 2'b01; frame_start = 1'b0; acs_msb_all = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      in_valid = 1'b0;
      tick();
    end
    check("mid_grp_idx", grp_idx, 4);
    check("mid_acs_en", acs_en, 1);
    #2 rst = 1'b1;
    #1;
    check_rst();
    m_bank = 0; m_addr = 0; m_cnt = 0; m_pend = 0;
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_hold_sym_done", sym_done, 0);
    check("rst_hold_in_ready", in_ready, 0);
    #3 rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("ready_after_midrun_rst", in_ready, 1);
    do_sym(2'($urandom_range(0, 3)), 1'b0, 8'($urandom), 1);
    do_sym(2'($urandom_range(0, 3)), 1'b1, 8'hFF, 0);
    do_sym(2'($urandom_range(0, 3)), 1'b0, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
